// File: rtl/sched_pkg.sv
// rtl/sched_pkg.sv - shared state type and phase-length helper for the tile scheduler
package sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_DONE
    } sched_state_t;

    // MULT phase length: the wavefront needs 2N-1 steps to drain through an N x N array.
    function automatic int mult_cycles(input int n, input int s);
        return (2 * n - 1) * s;
    endfunction

endpackage

// File: rtl/sched_row_stagger.sv
// rtl/sched_row_stagger.sv - staggered per-row multiply-enable mask generator
module sched_row_stagger #(
    parameter int MATRIX_SIZE = 4,
    parameter int STEP_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   advance,
    output logic [MATRIX_SIZE-1:0] row_mask
);

    localparam int SW = $clog2(STEP_CYCLES + 1);
    localparam logic [MATRIX_SIZE-1:0] FIRST_ROW = {1'b1, {(MATRIX_SIZE-1){1'b0}}};

    logic [SW-1:0] step_cnt;

    // The first advance after a clear lights the top row; every STEP_CYCLES advances
    // afterwards another row joins from the MSB side until the mask saturates.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            row_mask <= '0;
            step_cnt <= '0;
        end else if (clear) begin
            row_mask <= '0;
            step_cnt <= '0;
        end else if (advance) begin
            if (row_mask == '0) begin
                row_mask <= FIRST_ROW;
                step_cnt <= SW'(1);
            end else if (step_cnt == SW'(STEP_CYCLES)) begin
                row_mask <= {1'b1, row_mask[MATRIX_SIZE-1:1]};
                step_cnt <= SW'(1);
            end else begin
                step_cnt <= step_cnt + SW'(1);
            end
        end
    end

endmodule

// File: rtl/systolic_sched_v2.sv
// rtl/systolic_sched_v2.sv - LOAD/MULT tile sequencer for the weight-stationary systolic array
module systolic_sched_v2
    import sched_pkg::*;
#(
    parameter int MATRIX_SIZE = 4,
    parameter int STEP_CYCLES = 4,
    parameter int TILE_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   start,
    input  logic [TILE_W-1:0]      num_tiles,
    output logic                   busy,
    output logic [MATRIX_SIZE-1:0] load_weight,
    output logic [MATRIX_SIZE-1:0] enable_mult,
    output logic [TILE_W-1:0]      tile_idx,
    output logic                   done
);

    localparam int N   = MATRIX_SIZE;
    localparam int MC  = mult_cycles(MATRIX_SIZE, STEP_CYCLES);
    localparam int MCW = $clog2(MC + 1);
    localparam int RW  = $clog2(N + 1);

    sched_state_t      state;
    logic [RW-1:0]     row_cnt;
    logic [MCW-1:0]    mult_cnt;
    logic [TILE_W-1:0] tiles_q;
    logic [TILE_W:0]   next_tile;
    logic              last_load;
    logic              last_mult;
    logic              stagger_clear;
    logic              stagger_advance;

    assign next_tile = {1'b0, tile_idx} + (TILE_W + 1)'(1);
    assign last_load = (row_cnt == RW'(N));
    assign last_mult = (mult_cnt == MCW'(MC));

    // Stagger is advanced on the LOAD->MULT edge and every MULT cycle, cleared when MULT ends;
    // both are gated by en so a stall freezes the mask together with the FSM.
    always_comb begin
        stagger_clear   = 1'b0;
        stagger_advance = 1'b0;
        if (en) begin
            case (state)
                S_LOAD:  stagger_advance = last_load;
                S_MULT: begin
                    if (last_mult) begin
                        stagger_clear = 1'b1;
                    end else begin
                        stagger_advance = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    sched_row_stagger #(
        .MATRIX_SIZE (MATRIX_SIZE),
        .STEP_CYCLES (STEP_CYCLES)
    ) u_stagger (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (stagger_clear),
        .advance  (stagger_advance),
        .row_mask (enable_mult)
    );

    // Main FSM: row_cnt counts load strobes already issued, mult_cnt counts MULT cycles issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            row_cnt     <= '0;
            mult_cnt    <= '0;
            tiles_q     <= '0;
            tile_idx    <= '0;
            load_weight <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (en) begin
            case (state)
                S_IDLE: begin
                    if (start && (num_tiles != '0)) begin
                        tiles_q     <= num_tiles;
                        tile_idx    <= '0;
                        row_cnt     <= RW'(1);
                        mult_cnt    <= '0;
                        load_weight <= N'(1);
                        busy        <= 1'b1;
                        state       <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (last_load) begin
                        load_weight <= '0;
                        row_cnt     <= '0;
                        mult_cnt    <= MCW'(1);
                        state       <= S_MULT;
                    end else begin
                        load_weight <= N'(1) << row_cnt;
                        row_cnt     <= row_cnt + RW'(1);
                    end
                end
                S_MULT: begin
                    if (last_mult) begin
                        mult_cnt <= '0;
                        if (next_tile < {1'b0, tiles_q}) begin
                            tile_idx    <= next_tile[TILE_W-1:0];
                            row_cnt     <= RW'(1);
                            load_weight <= N'(1);
                            state       <= S_LOAD;
                        end else begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end else begin
                        mult_cnt <= mult_cnt + MCW'(1);
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_sched_v2.sv
// tb/tb_systolic_sched_v2.sv - scoreboard bench for systolic_sched_v2 (N=4/S=4 and N=2/S=1)
module tb_systolic_sched_v2;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [7:0] num_tiles = 8'd0;

    logic       busy_a, done_a;
    logic [3:0] lw_a, em_a;
    logic [7:0] ti_a;
    logic       busy_b, done_b;
    logic [1:0] lw_b, em_b;
    logic [7:0] ti_b;

    int edge_n = 0;
    int checks = 0;
    int passes = 0;

    typedef struct {
        int         t;
        bit         d;
        logic [3:0] lw;
        logic [3:0] em;
        logic [7:0] ti;
        logic       bz;
        logic       dn;
        bit         cti;
        string      nm;
    } rec_t;

    rec_t recq[$];
    int   doneq_a[$];
    int   doneq_b[$];

    systolic_sched_v2 #(.MATRIX_SIZE(4), .STEP_CYCLES(4), .TILE_W(8)) dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .start       (start_a),
        .num_tiles   (num_tiles),
        .busy        (busy_a),
        .load_weight (lw_a),
        .enable_mult (em_a),
        .tile_idx    (ti_a),
        .done        (done_a)
    );

    systolic_sched_v2 #(.MATRIX_SIZE(2), .STEP_CYCLES(1), .TILE_W(8)) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .start       (start_b),
        .num_tiles   (num_tiles),
        .busy        (busy_b),
        .load_weight (lw_b),
        .enable_mult (em_b),
        .tile_idx    (ti_b),
        .done        (done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic void push_rec(int t, bit d, logic [3:0] lw, logic [3:0] em, logic [7:0] ti,
                                     logic bz, logic dn, bit cti, string nm);
        rec_t r;
        int   i;
        r.t = t; r.d = d; r.lw = lw; r.em = em; r.ti = ti;
        r.bz = bz; r.dn = dn; r.cti = cti; r.nm = nm;
        i = 0;
        while (i < recq.size() && recq[i].t <= t) i++;
        recq.insert(i, r);
    endfunction

    // Expected cycle c of a run whose start was sampled at edge b is observed at edge_n == b+c-1.
    function automatic void ea(int b, int c, logic [3:0] lw, logic [3:0] em, logic [7:0] ti,
                               logic bz, logic dn, bit cti, string nm);
        push_rec(b + c - 1, 1'b0, lw, em, ti, bz, dn, cti, nm);
    endfunction

    function automatic void expect_single(int b, string nm);
        ea(b, 1,  4'b0001, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c1"});
        ea(b, 2,  4'b0010, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c2"});
        ea(b, 3,  4'b0100, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c3"});
        ea(b, 4,  4'b1000, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c4"});
        ea(b, 5,  4'b0000, 4'b1000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c5"});
        ea(b, 8,  4'b0000, 4'b1000, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c8"});
        ea(b, 9,  4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c9"});
        ea(b, 12, 4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c12"});
        ea(b, 13, 4'b0000, 4'b1110, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c13"});
        ea(b, 16, 4'b0000, 4'b1110, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c16"});
        ea(b, 17, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c17"});
        ea(b, 32, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, {nm, "_c32"});
        ea(b, 33, 4'b0000, 4'b0000, 8'd0, 1'b1, 1'b1, 1'b1, {nm, "_c33"});
        ea(b, 34, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, {nm, "_c34"});
        doneq_a.push_back(b + 32);
    endfunction

    task automatic begin_start_a(input logic [7:0] tiles, output int b);
        @(negedge clk);
        start_a   = 1'b1;
        num_tiles = tiles;
        b = edge_n + 1;
    endtask

    task automatic begin_start_b(input logic [7:0] tiles, output int b);
        @(negedge clk);
        start_b   = 1'b1;
        num_tiles = tiles;
        b = edge_n + 1;
    endtask

    task automatic end_start();
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Monitor: pops every scheduled snapshot when its cycle arrives and matches every done pulse.
    always @(negedge clk) begin : monitor
        rec_t       r;
        logic [3:0] alw, aem;
        logic [7:0] ati;
        logic       abz, adn;
        int         e;
        while (recq.size() > 0 && recq[0].t <= edge_n) begin
            r = recq.pop_front();
            if (r.d) begin
                alw = {2'b00, lw_b}; aem = {2'b00, em_b}; ati = ti_b; abz = busy_b; adn = done_b;
            end else begin
                alw = lw_a; aem = em_a; ati = ti_a; abz = busy_a; adn = done_a;
            end
            if (!r.cti) r.ti = ati;
            checks++;
            if (r.t != edge_n) begin
                $display("FAIL %s snapshot missed: at edge %0d, wanted edge %0d", r.nm, edge_n, r.t);
            end else if ({alw, aem, ati, abz, adn} !== {r.lw, r.em, r.ti, r.bz, r.dn}) begin
                $display("FAIL %s lw/em/ti/busy/done got %b/%b/%0d/%b/%b want %b/%b/%0d/%b/%b",
                         r.nm, alw, aem, ati, abz, adn, r.lw, r.em, r.ti, r.bz, r.dn);
            end else begin
                passes++;
            end
        end
        if (done_a === 1'b1) begin
            checks++;
            if (doneq_a.size() == 0) begin
                $display("FAIL done_a unexpected pulse at edge %0d, want none", edge_n);
            end else begin
                e = doneq_a.pop_front();
                if (e == edge_n) passes++;
                else $display("FAIL done_a timing got edge %0d want edge %0d", edge_n, e);
            end
        end
        if (done_b === 1'b1) begin
            checks++;
            if (doneq_b.size() == 0) begin
                $display("FAIL done_b unexpected pulse at edge %0d, want none", edge_n);
            end else begin
                e = doneq_b.pop_front();
                if (e == edge_n) passes++;
                else $display("FAIL done_b timing got edge %0d want edge %0d", edge_n, e);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired at edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int b;

        // Reset state
        @(negedge clk);
        push_rec(edge_n + 1, 1'b0, 4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 1'b1, "reset_a");
        push_rec(edge_n + 1, 1'b1, 4'b0, 4'b0, 8'd0, 1'b0, 1'b0, 1'b1, "reset_b");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single tile
        begin_start_a(8'd1, b);
        expect_single(b, "t1");
        end_start();
        repeat (36) @(negedge clk);

        // Three tiles back to back
        begin_start_a(8'd3, b);
        ea(b, 1,  4'b0001, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, "t2_c1");
        ea(b, 32, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, "t2_c32");
        ea(b, 33, 4'b0001, 4'b0000, 8'd1, 1'b1, 1'b0, 1'b1, "t2_c33");
        ea(b, 37, 4'b0000, 4'b1000, 8'd1, 1'b1, 1'b0, 1'b1, "t2_c37");
        ea(b, 64, 4'b0000, 4'b1111, 8'd1, 1'b1, 1'b0, 1'b1, "t2_c64");
        ea(b, 65, 4'b0001, 4'b0000, 8'd2, 1'b1, 1'b0, 1'b1, "t2_c65");
        ea(b, 96, 4'b0000, 4'b1111, 8'd2, 1'b1, 1'b0, 1'b1, "t2_c96");
        ea(b, 97, 4'b0000, 4'b0000, 8'd2, 1'b1, 1'b1, 1'b1, "t2_c97");
        ea(b, 98, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t2_c98");
        doneq_a.push_back(b + 96);
        end_start();
        repeat (100) @(negedge clk);

        // Five-cycle stall mid-MULT
        begin_start_a(8'd1, b);
        ea(b, 9,  4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c9");
        ea(b, 10, 4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c10");
        ea(b, 14, 4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c14");
        ea(b, 17, 4'b0000, 4'b1100, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c17");
        ea(b, 18, 4'b0000, 4'b1110, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c18");
        ea(b, 22, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c22");
        ea(b, 37, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, "t3_c37");
        ea(b, 38, 4'b0000, 4'b0000, 8'd0, 1'b1, 1'b1, 1'b1, "t3_c38");
        ea(b, 39, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t3_c39");
        doneq_a.push_back(b + 37);
        end_start();
        repeat (8) @(negedge clk);
        en = 1'b0;
        repeat (5) @(negedge clk);
        en = 1'b1;
        repeat (30) @(negedge clk);

        // Reset mid-run, then a clean run
        begin_start_a(8'd1, b);
        ea(b, 20, 4'b0000, 4'b1111, 8'd0, 1'b1, 1'b0, 1'b1, "t4_c20");
        ea(b, 21, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, "t4_c21");
        ea(b, 22, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b1, "t4_c22");
        end_start();
        repeat (19) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        begin_start_a(8'd1, b);
        expect_single(b, "t4r");
        end_start();
        repeat (36) @(negedge clk);

        // start while busy and during the done cycle is ignored
        begin_start_a(8'd1, b);
        expect_single(b, "t5");
        ea(b, 35, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t5_c35");
        end_start();
        repeat (9) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (22) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);

        // num_tiles == 0 is ignored
        begin_start_a(8'd0, b);
        ea(b, 1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t5z_c1");
        ea(b, 2, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t5z_c2");
        ea(b, 3, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t5z_c3");
        end_start();
        repeat (40) @(negedge clk);

        // N=2, STEP_CYCLES=1 instance
        begin_start_b(8'd1, b);
        push_rec(b,     1'b1, 4'b0001, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, "t6_c1");
        push_rec(b + 1, 1'b1, 4'b0010, 4'b0000, 8'd0, 1'b1, 1'b0, 1'b1, "t6_c2");
        push_rec(b + 2, 1'b1, 4'b0000, 4'b0010, 8'd0, 1'b1, 1'b0, 1'b1, "t6_c3");
        push_rec(b + 3, 1'b1, 4'b0000, 4'b0011, 8'd0, 1'b1, 1'b0, 1'b1, "t6_c4");
        push_rec(b + 4, 1'b1, 4'b0000, 4'b0011, 8'd0, 1'b1, 1'b0, 1'b1, "t6_c5");
        push_rec(b + 5, 1'b1, 4'b0000, 4'b0000, 8'd0, 1'b1, 1'b1, 1'b1, "t6_c6");
        push_rec(b + 6, 1'b1, 4'b0000, 4'b0000, 8'd0, 1'b0, 1'b0, 1'b0, "t6_c7");
        doneq_b.push_back(b + 5);
        end_start();
        repeat (10) @(negedge clk);

        // Everything scheduled must have been consumed
        checks++;
        if (recq.size() == 0) passes++;
        else $display("FAIL snapshots_left got %0d want 0", recq.size());
        checks++;
        if (doneq_a.size() == 0) passes++;
        else $display("FAIL done_a_missing got %0d pending want 0", doneq_a.size());
        checks++;
        if (doneq_b.size() == 0) passes++;
        else $display("FAIL done_b_missing got %0d pending want 0", doneq_b.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
